// File: rtl/keypad_pkg.sv
// Shared encodings and helpers for the 4x4 matrix keypad scanner.
package keypad_pkg;

    typedef logic [1:0] state_t;

    localparam state_t SCAN     = 2'd0;
    localparam state_t DEBOUNCE = 2'd1;
    localparam state_t PRESSED  = 2'd2;
    localparam state_t RELEASE  = 2'd3;

    localparam logic [3:0] ROW_IDLE  = 4'b1111;
    localparam logic [3:0] ROW_FIRST = 4'b1110;
    localparam logic [3:0] COL_IDLE  = 4'b1111;

    // True when exactly one bit of an active-low vector is asserted.
    function automatic logic single_low(input logic [3:0] v);
        logic [3:0] a;
        a = ~v;
        return (a != 4'd0) && ((a & (a - 4'd1)) == 4'd0);
    endfunction

    function automatic logic [1:0] low_idx(input logic [3:0] v);
        logic [1:0] idx;
        idx = 2'd0;
        if (!v[1]) idx = 2'd1;
        if (!v[2]) idx = 2'd2;
        if (!v[3]) idx = 2'd3;
        return idx;
    endfunction

    // Walk the low bit upward; an all-high row vector restarts at row 0.
    function automatic logic [3:0] rotate_row(input logic [3:0] r);
        return (r == ROW_IDLE) ? ROW_FIRST : {r[2:0], r[3]};
    endfunction

endpackage

// File: rtl/keypad_scan_if.sv
// Keypad pin and key-report bundle between the scanner and its surroundings.
interface keypad_scan_if;

    logic [3:0] col;
    logic [3:0] row;
    logic [3:0] key;
    logic       key_valid;
    logic       key_held;

    modport master (
        output col,
        input  row,
        input  key,
        input  key_valid,
        input  key_held
    );

    modport slave (
        input  col,
        output row,
        output key,
        output key_valid,
        output key_held
    );

endinterface

// File: rtl/sync_2ff.sv
// Two-flop synchroniser with a configurable reset value.
module sync_2ff #(
    parameter int unsigned      WIDTH   = 4,
    parameter logic [WIDTH-1:0] RST_VAL = '1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= RST_VAL;
            q    <= RST_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/keypad_scan.sv
// 4x4 keypad scanner: row rotation, column debounce and one-shot key reporting.
module keypad_scan
    import keypad_pkg::*;
#(
    parameter int unsigned SCAN_N   = 16,
    parameter int unsigned DB_TICKS = 4
) (
    input  logic          clk,
    input  logic          rst,
    keypad_scan_if.slave  kp
);

    localparam int unsigned   CNT_W    = (DB_TICKS > 1) ? $clog2(DB_TICKS) : 1;
    // Value of cnt on the tick that will take it to DB_TICKS-1.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_TICKS - 2);

    logic [SCAN_N-1:0] presc_q, presc_d;
    state_t            state_q, state_d;
    logic [3:0]        row_q, row_d;
    logic [3:0]        pat_q, pat_d;
    logic [3:0]        key_q, key_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              valid_q, valid_d;
    logic [3:0]        col_s;
    logic              tick;
    logic              idle;

    sync_2ff #(
        .WIDTH   (4),
        .RST_VAL (COL_IDLE)
    ) u_col_sync (
        .clk (clk),
        .rst (rst),
        .d   (kp.col),
        .q   (col_s)
    );

    assign tick = &presc_q;
    assign idle = (col_s == COL_IDLE);

    always_comb begin
        presc_d = presc_q + SCAN_N'(1);
        state_d = state_q;
        row_d   = row_q;
        pat_d   = pat_q;
        key_d   = key_q;
        cnt_d   = cnt_q;
        valid_d = 1'b0;
        if (tick) begin
            case (state_q)
                SCAN: begin
                    if (single_low(col_s)) begin
                        state_d = DEBOUNCE;
                        pat_d   = col_s;
                        cnt_d   = '0;
                    end else begin
                        row_d = rotate_row(row_q);
                    end
                end
                DEBOUNCE: begin
                    if (col_s == pat_q) begin
                        cnt_d = cnt_q + CNT_W'(1);
                        if (cnt_q == CNT_LAST) begin
                            state_d = PRESSED;
                            key_d   = {low_idx(row_q), low_idx(pat_q)};
                            valid_d = 1'b1;
                        end
                    end else begin
                        state_d = SCAN;
                        cnt_d   = '0;
                        row_d   = rotate_row(row_q);
                    end
                end
                PRESSED: begin
                    if (idle) begin
                        state_d = RELEASE;
                        cnt_d   = '0;
                    end
                end
                RELEASE: begin
                    if (idle) begin
                        cnt_d = cnt_q + CNT_W'(1);
                        if (cnt_q == CNT_LAST) begin
                            state_d = SCAN;
                            row_d   = rotate_row(row_q);
                        end
                    end else begin
                        // A bounce during release resumes the press silently.
                        state_d = PRESSED;
                    end
                end
                default: begin
                    state_d = SCAN;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc_q <= '0;
            state_q <= SCAN;
            row_q   <= ROW_FIRST;
            pat_q   <= COL_IDLE;
            key_q   <= 4'd0;
            cnt_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            presc_q <= presc_d;
            state_q <= state_d;
            row_q   <= row_d;
            pat_q   <= pat_d;
            key_q   <= key_d;
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
        end
    end

    assign kp.row       = row_q;
    assign kp.key       = key_q;
    assign kp.key_valid = valid_q;
    assign kp.key_held  = (state_q == PRESSED) || (state_q == RELEASE);

endmodule
